// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with pointer control, occupancy count,
//             almost-full/almost-empty thresholds, sticky overflow/underflow
//             flags and selectable registered or first-word-fall-through read.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR     = 5,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0] c_FULL_CNT = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] c_AF_CNT   = (ADDR+1)'(AF_LEVEL);
    localparam logic [ADDR:0] c_AE_CNT   = (ADDR+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR:0]    wptr_q, wptr_d;
    logic [ADDR:0]    rptr_q, rptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Status flags depend only on the registered count, never on requests.
    assign wfull        = (count_q == c_FULL_CNT);
    assign rempty       = (count_q == '0);
    assign almost_full  = (count_q >= c_AF_CNT);
    assign almost_empty = (count_q <= c_AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign w_wr_ok = write & ~wfull;
    assign w_rd_ok = read & ~rempty;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        if (w_wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A fresh error outranks a simultaneous clear.
        if (write & wfull) begin
            overflow_d = 1'b1;
        end
        if (read & rempty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; every entry clears on reset so FWFT output is defined.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            mem_q[wptr_q[ADDR-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word presented directly from the array.
            assign rdata = mem_q[rptr_q[ADDR-1:0]];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;

            // Registered read data, updated only on an accepted read.
            always_ff @(posedge clk or negedge reset_b) begin
                if (!reset_b) begin
                    rdata_q <= '0;
                end else if (w_rd_ok) begin
                    rdata_q <= mem_q[rptr_q[ADDR-1:0]];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule
`default_nettype wire
